// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: processor mode encodings,
// frame width and the loader state type.
package prog_loader_pkg;

  localparam int unsigned FRAME_W = 12;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_ICS  = 2'b01;
  localparam logic [1:0] CMD_DCS  = 2'b10;
  localparam logic [1:0] CMD_RUN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_RUN_START,
    ST_RUN_WAIT
  } state_t;

endpackage

// File: rtl/frame_serializer.sv
// 12-bit LSB-first shift register with a bit counter; last flags the final bit.
module frame_serializer
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] word,
  output logic               bit_out,
  output logic               last
);

  logic [FRAME_W-1:0] sreg;
  logic [3:0]         bit_cnt;

  // Load a new word or advance one bit toward the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= word;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= {1'b0, sreg[FRAME_W-1:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign bit_out = sreg[0];
  assign last    = (bit_cnt == 4'(FRAME_W - 1));

endmodule

// File: rtl/prog_loader.sv
// Host-to-processor program loader: serializes cache frames over cmd/mosi
// and supervises program runs with a completion/timeout watchdog.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned RUN_TIMEOUT = 1023,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  output logic       frame_ready,
  input  logic       frame_is_data,
  input  logic [3:0] frame_addr,
  input  logic [7:0] frame_data,
  input  logic       run_req,
  input  logic       proc_done,
  output logic [1:0] cmd,
  output logic       mosi,
  output logic       busy,
  output logic       run_done,
  output logic       run_timeout
);

  localparam logic [15:0] TO_LAST  = 16'(RUN_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic        is_data;
  logic [15:0] cnt;
  logic        handshake;
  logic        timeout_hit;
  logic        ser_bit;
  logic        ser_last;

  assign frame_ready = (state == ST_IDLE) && !rst;
  assign handshake   = frame_valid && frame_ready;
  assign timeout_hit = (cnt == TO_LAST);
  assign busy        = (state != ST_IDLE);

  frame_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (handshake),
    .shift   (state == ST_SHIFT),
    .word    ({frame_data, frame_addr}),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  // Loader sequencing; cnt is shared between the gap timer and the run watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      is_data <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            is_data <= frame_is_data;
            state   <= ST_SHIFT;
          end else if (run_req) begin
            state <= ST_RUN_START;
          end
        end
        ST_SHIFT: begin
          if (ser_last) begin
            state <= ST_GAP;
            cnt   <= '0;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) state <= ST_IDLE;
          else                 cnt   <= cnt + 16'd1;
        end
        ST_RUN_START: begin
          state <= ST_RUN_WAIT;
          cnt   <= '0;
        end
        ST_RUN_WAIT: begin
          if (proc_done) begin
            state <= ST_IDLE;
          end else if (timeout_hit) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Mode lines and pulses; RUN_WAIT drops cmd the same cycle done/timeout occurs.
  always_comb begin
    cmd         = CMD_NONE;
    mosi        = 1'b0;
    run_done    = 1'b0;
    run_timeout = 1'b0;
    unique case (state)
      ST_SHIFT: begin
        cmd  = is_data ? CMD_DCS : CMD_ICS;
        mosi = ser_bit;
      end
      ST_RUN_START: cmd = CMD_RUN;
      ST_RUN_WAIT: begin
        if (proc_done)        run_done    = 1'b1;
        else if (timeout_hit) run_timeout = 1'b1;
        else                  cmd         = CMD_RUN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-cycle expectation scoreboard,
// table-driven frames, directed run/timeout/reset sequences, processor model.
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic       frame_valid;
  logic       frame_is_data;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic       run_req;
  logic       p_done;
  logic       frame_ready, mosi, busy, run_done, run_timeout;
  logic [1:0] cmd;

  logic       t_valid, t_req, t_done;
  logic       t_ready, t_mosi, t_busy, t_run_done, t_run_timeout;
  logic [1:0] t_cmd;

  prog_loader #(.RUN_TIMEOUT(1023), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_is_data(frame_is_data), .frame_addr(frame_addr), .frame_data(frame_data),
    .run_req(run_req), .proc_done(p_done), .cmd(cmd), .mosi(mosi), .busy(busy),
    .run_done(run_done), .run_timeout(run_timeout)
  );

  prog_loader #(.RUN_TIMEOUT(8), .GAP_CYCLES(1)) dut_to (
    .clk(clk), .rst(rst), .frame_valid(t_valid), .frame_ready(t_ready),
    .frame_is_data(frame_is_data), .frame_addr(frame_addr), .frame_data(frame_data),
    .run_req(t_req), .proc_done(t_done), .cmd(t_cmd), .mosi(t_mosi), .busy(t_busy),
    .run_done(t_run_done), .run_timeout(t_run_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] v;
    string      nm;
  } exp_t;

  typedef struct {
    logic       isd;
    logic [3:0] a;
    logic [7:0] d;
    logic [11:0] w;
  } vec_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic sel = 1'b0;
  logic [6:0] act;

  // expected vector layout: {cmd, mosi, ready, busy, run_done, run_timeout}
  function automatic logic [6:0] ex(input logic [1:0] c, input logic m, input logic r,
                                    input logic b, input logic d, input logic t);
    return {c, m, r, b, d, t};
  endfunction

  localparam logic [6:0] E_IDLE = 7'b00_0_1_0_0_0;
  localparam logic [6:0] E_RST  = 7'b00_0_0_0_0_0;
  localparam logic [6:0] E_RUN  = 7'b11_0_0_1_0_0;
  localparam logic [6:0] E_DONE = 7'b00_0_0_1_1_0;
  localparam logic [6:0] E_TMO  = 7'b00_0_0_1_0_1;
  localparam logic [6:0] E_GAP  = 7'b00_0_0_1_0_0;

  task automatic push(input string nm, input logic [6:0] v);
    exp_t x;
    x.v  = v;
    x.nm = nm;
    sbq.push_back(x);
  endtask

  // Scoreboard checker: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      act = sel ? {t_cmd, t_mosi, t_ready, t_busy, t_run_done, t_run_timeout}
                : {cmd, mosi, frame_ready, busy, run_done, run_timeout};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got cmd,mosi,rdy,busy,done,tmo=%b required %b", e.nm, act, e.v);
      end
    end
  end

  // Processor model: collects serialized bits and writes its caches.
  logic [7:0]  icache [16];
  logic [7:0]  dcache [16];
  logic [11:0] pw;
  int unsigned pn = 0;
  int unsigned wcount = 0;

  initial begin
    for (int unsigned i = 0; i < 16; i++) begin
      icache[i] = '0;
      dcache[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst && (cmd == 2'b01 || cmd == 2'b10)) begin
      pw[pn[3:0]] = mosi;
      if (pn == 11) begin
        if (cmd == 2'b10) dcache[pw[3:0]] = pw[11:4];
        else              icache[pw[3:0]] = pw[11:4];
        wcount++;
        pn = 0;
      end else begin
        pn++;
      end
    end else begin
      pn = 0;
    end
  end

  task automatic wait_drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Starts at a cycle boundary; offers a frame, then scrambles fields while shifting.
  task automatic send_frame(input logic isd, input logic [3:0] a, input logic [7:0] d,
                            input logic [11:0] w, input string nm);
    frame_valid   = 1'b1;
    frame_is_data = isd;
    frame_addr    = a;
    frame_data    = d;
    push({nm, "_hs"}, E_IDLE);
    for (int k = 0; k < 12; k++)
      push($sformatf("%s_bit%0d", nm, k), ex(isd ? 2'b10 : 2'b01, w[k], 1'b0, 1'b1, 1'b0, 1'b0));
    push({nm, "_gap"}, E_GAP);
    push({nm, "_ready"}, E_IDLE);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      frame_is_data = 1'($urandom);
      frame_addr    = 4'($urandom);
      frame_data    = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  task automatic check_cache(input logic isd, input logic [3:0] a, input logic [7:0] d,
                             input string nm);
    logic [7:0] got;
    got = isd ? dcache[a] : icache[a];
    tests++;
    if (got !== d) begin
      fails++;
      $display("FAIL %s: model cache[%h]=%h required %h", nm, a, got, d);
    end
  endtask

  vec_t vecs [4];
  int unsigned wbefore;
  logic [11:0] wr;

  initial begin
    vecs[0] = '{isd: 1'b0, a: 4'h3, d: 8'hA5, w: 12'hA53};
    vecs[1] = '{isd: 1'b1, a: 4'hF, d: 8'h80, w: 12'h80F};
    vecs[2] = '{isd: 1'b0, a: 4'h0, d: 8'hFF, w: 12'hFF0};
    vecs[3] = '{isd: 1'b1, a: 4'hA, d: 8'h3C, w: 12'h3CA};

    rst = 1'b1; frame_valid = 1'b0; frame_is_data = 1'b0; frame_addr = '0; frame_data = '0;
    run_req = 1'b0; p_done = 1'b0; t_valid = 1'b0; t_req = 1'b0; t_done = 1'b0;

    // reset state
    @(posedge clk); #1;
    push("reset_c2", E_RST);
    push("reset_c3", E_RST);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    push("reset_release", E_IDLE);
    wait_drain();
    sel = 1'b1;
    push("reset_release_to", E_IDLE);
    wait_drain();
    sel = 1'b0;

    // table-driven frames
    for (int unsigned i = 0; i < 4; i++) begin
      send_frame(vecs[i].isd, vecs[i].a, vecs[i].d, vecs[i].w, $sformatf("frame%0d", i));
      check_cache(vecs[i].isd, vecs[i].a, vecs[i].d, $sformatf("cache%0d", i));
    end

    // run completing after 20 busy cycles
    run_req = 1'b1;
    push("run_idle", E_IDLE);
    push("run_start", E_RUN);
    for (int k = 0; k < 20; k++) push($sformatf("run_wait%0d", k), E_RUN);
    push("run_done", E_DONE);
    push("run_after", E_IDLE);
    @(posedge clk); #1;
    run_req = 1'b0;
    repeat (21) begin @(posedge clk); #1; end
    p_done = 1'b1;
    @(posedge clk); #1;
    p_done = 1'b0;
    wait_drain();

    // run_req held across completion must pass through IDLE
    run_req = 1'b1; p_done = 1'b1;
    push("hold_idle", E_IDLE);
    push("hold_start1", E_RUN);
    push("hold_done1", E_DONE);
    push("hold_idle_mid", E_IDLE);
    push("hold_start2", E_RUN);
    push("hold_done2", E_DONE);
    push("hold_idle_end", E_IDLE);
    repeat (4) begin @(posedge clk); #1; end
    run_req = 1'b0;
    wait_drain();
    p_done = 1'b0;

    // frame wins over run_req, run follows after GAP and one IDLE cycle
    run_req = 1'b1;
    send_frame(1'b0, 4'h5, 8'h17, 12'h175, "prio");
    run_req = 1'b0; p_done = 1'b1;
    push("prio_run_start", E_RUN);
    push("prio_run_done", E_DONE);
    push("prio_idle", E_IDLE);
    wait_drain();
    p_done = 1'b0;
    check_cache(1'b0, 4'h5, 8'h17, "prio_cache");

    // watchdog expiry (RUN_TIMEOUT=8)
    sel = 1'b1;
    t_req = 1'b1;
    push("to_idle", E_IDLE);
    push("to_start", E_RUN);
    for (int k = 0; k < 7; k++) push($sformatf("to_wait%0d", k), E_RUN);
    push("to_pulse", E_TMO);
    push("to_gap", E_GAP);
    push("to_idle_end", E_IDLE);
    @(posedge clk); #1;
    t_req = 1'b0;
    wait_drain();

    // proc_done coinciding with the timeout cycle: done wins
    t_req = 1'b1;
    push("tie_idle", E_IDLE);
    push("tie_start", E_RUN);
    for (int k = 0; k < 7; k++) push($sformatf("tie_wait%0d", k), E_RUN);
    push("tie_done", E_DONE);
    push("tie_idle_end", E_IDLE);
    @(posedge clk); #1;
    t_req = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    t_done = 1'b1;
    @(posedge clk); #1;
    t_done = 1'b0;
    wait_drain();
    sel = 1'b0;

    // reset during the 6th SHIFT cycle aborts the frame
    wbefore = wcount;
    wr = 12'h992;
    frame_valid = 1'b1; frame_is_data = 1'b1; frame_addr = 4'h2; frame_data = 8'h99;
    push("abort_hs", E_IDLE);
    for (int k = 0; k < 6; k++)
      push($sformatf("abort_bit%0d", k), ex(2'b10, wr[k], 1'b0, 1'b1, 1'b0, 1'b0));
    push("abort_after_rst", E_IDLE);
    push("abort_idle", E_IDLE);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();
    tests++;
    if (wcount != wbefore) begin
      fails++;
      $display("FAIL abort_writes: model writes %0d required %0d", wcount, wbefore);
    end
    check_cache(1'b1, 4'h2, 8'h00, "abort_cache");

    // recovery after abort
    send_frame(vecs[0].isd, 4'h7, 8'h4E, 12'h4E7, "recover");
    check_cache(1'b0, 4'h7, 8'h4E, "recover_cache");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
